// File: rtl/e203_wfi_ctrl.sv
// e203_wfi_ctrl: WFI sleep entry/exit sequencer on the always-on clock
module e203_wfi_ctrl #(
  parameter int WAKE_DLY = 2,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wfi_req_valid,
  output logic             wfi_req_ready,
  input  logic             dbg_mode,
  input  logic             oitf_empty,
  input  logic             lsu_idle,
  input  logic             biu_idle,
  input  logic             irq_pending,
  input  logic             dbg_req,
  output logic             halt_ifu_req,
  output logic             core_wfi,
  output logic             wake_pulse,
  output logic [CNT_W-1:0] sleep_cnt,
  input  logic             sleep_cnt_clr
);
  typedef enum logic [1:0] {RUN, DRAIN, SLEEP, WAKE} state_t;
  localparam int DLY = (WAKE_DLY < 1) ? 1 : WAKE_DLY;
  localparam int DW  = $clog2(DLY + 1);
  state_t          state, state_nxt;
  logic [DW-1:0]   dly_cnt;
  logic            hs, wake, idle, halt_nxt, wfi_nxt, pulse_nxt;
  assign wfi_req_ready = (state == RUN);
  assign hs   = wfi_req_valid & wfi_req_ready;
  assign wake = irq_pending | dbg_req;
  assign idle = oitf_empty & lsu_idle & biu_idle;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      dly_cnt      <= '0;
      halt_ifu_req <= 1'b0;
      core_wfi     <= 1'b0;
      wake_pulse   <= 1'b0;
      sleep_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      dly_cnt      <= (state != WAKE) ? DW'(DLY) : dly_cnt - 1'b1;
      halt_ifu_req <= halt_nxt;
      core_wfi     <= wfi_nxt;
      wake_pulse   <= pulse_nxt;
      sleep_cnt    <= sleep_cnt_clr ? '0 :
                      (state == SLEEP && !(&sleep_cnt)) ? sleep_cnt + 1'b1 : sleep_cnt;
    end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = (hs && !dbg_mode) ? DRAIN : RUN;
      DRAIN:   state_nxt = wake ? WAKE : idle ? SLEEP : DRAIN;
      SLEEP:   state_nxt = wake ? WAKE : SLEEP;
      WAKE:    state_nxt = (dly_cnt <= DW'(1)) ? RUN : WAKE;
      default: state_nxt = RUN;
    endcase
  end
  // outputs are registered from the next state so they line up with it
  always_comb begin
    halt_nxt  = (state_nxt != RUN);
    wfi_nxt   = (state_nxt == SLEEP);
    pulse_nxt = (state == WAKE && state_nxt == RUN) || (hs && dbg_mode);
  end
endmodule
